uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entry count; SHALL be a power of two, 2..256.
REQ-002 Parameter ACK_TIMEOUT, default 15, maximum cycles to wait for i_tx_busy after a start pulse.
REQ-003 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_wr_en  in  1  push request, one byte per asserted cycle.
REQ-006 i_wr_data  in  8  byte to push.
REQ-007 i_ovf_clr  in  1  clears o_overflow and o_ack_err.
REQ-008 i_tx_busy  in  1  transmitter busy status.
REQ-009 o_tx_start  out  1  one-cycle launch pulse to the transmitter.
REQ-010 o_tx_data  out  8  byte presented with o_tx_start.
REQ-011 o_full / o_empty  out  1 each  FIFO status, registered.
REQ-012 o_count  out  $clog2(DEPTH)+1  bytes stored, registered.
REQ-013 o_overflow  out  1  sticky: a push was dropped.
REQ-014 o_ack_err  out  1  sticky: transmitter never acknowledged a launch.

Function
REQ-015 A push SHALL be accepted iff i_wr_en=1 and o_full=0; the byte is stored at the write pointer and the pointer increments mod DEPTH.
REQ-016 A push while o_full=1 SHALL be dropped, with the FIFO unchanged and o_overflow set on the next edge.
REQ-017 A push and a pop in the same cycle SHALL leave o_count unchanged; both pointers advance.
REQ-018 o_full SHALL equal (o_count==DEPTH); o_empty SHALL equal (o_count==0); both are derived from the updated count on the same edge.
REQ-019 The drain FSM SHALL have states IDLE, LAUNCH, WAIT_ACK and WAIT_DONE.
REQ-020 IDLE->LAUNCH SHALL occur when o_empty=0 and i_tx_busy=0.
REQ-021 LAUNCH SHALL last exactly one cycle and assert o_tx_start=1.
REQ-022 On the edge ending LAUNCH, o_tx_data SHALL hold the head byte, and that pop SHALL be the only read-pointer advance.
REQ-023 o_tx_data SHALL stay stable until the next LAUNCH.
REQ-024 LAUNCH->WAIT_ACK SHALL be unconditional.
REQ-025 WAIT_ACK->WAIT_DONE SHALL occur when i_tx_busy=1.
REQ-026 WAIT_ACK->IDLE SHALL occur after ACK_TIMEOUT cycles with i_tx_busy=0; o_ack_err SHALL be set and the byte is lost.
REQ-027 WAIT_DONE->IDLE SHALL occur when i_tx_busy=0.
REQ-028 Minimum spacing between start pulses SHALL be 3 cycles; o_tx_start SHALL never be asserted while i_tx_busy=1.
REQ-029 i_ovf_clr SHALL clear both sticky flags; if a set event coincides with the clear, the set SHALL win.
REQ-030 Latency: a byte pushed into an empty FIFO with the transmitter idle SHALL produce o_tx_start 2 cycles after the push edge.

Reset
REQ-031 On i_rst_n=0, the block SHALL immediately force: FSM to IDLE; pointers and o_count to 0; o_empty=1; o_full=0; o_tx_start=0; o_tx_data=8'h00; o_overflow=0; o_ack_err=0; timeout counter to 0.
REQ-032 Reset mid-transfer SHALL discard all stored bytes, and no start pulse SHALL be issued in the first cycle after release.
REQ-033 FIFO storage contents need not be reset.

Structure
REQ-034 FSM state encodings SHALL live in a shared UART definitions package alongside the transmitter constants.
REQ-035 Storage, pointers and count SHALL be a sub-module, fifo_sync (parameters DEPTH and WIDTH); the drain FSM SHALL stay in uart_tx_fifo.

Verification
REQ-036 Single byte: push 8'hA5 into an empty FIFO with the transmitter model idle -> o_tx_start pulse 2 cycles later, o_tx_data=8'hA5, o_empty=1 after the pop.
REQ-037 Burst: push 8'h01..8'h10 (16 bytes) back-to-back with a transmitter model (busy 1 cycle after start, 20 cycles long) -> bytes emitted in order 01..10, exactly 16 start pulses, none while busy.
REQ-038 Overflow: fill DEPTH=16 with the transmitter stalled busy, then push 8'hFF -> o_full=1, o_count=16, o_overflow=1, 8'hFF never transmitted; pulse i_ovf_clr -> o_overflow=0.
REQ-039 Simultaneous: with o_count=16, push during the LAUNCH cycle -> o_count stays 16 and the new byte is transmitted last.
REQ-040 Ack timeout: transmitter model never raises busy -> o_ack_err=1 after 15 cycles in WAIT_ACK, FSM returns to IDLE, and the next byte launches.
REQ-041 Reset mid-operation: assert i_rst_n=0 during WAIT_DONE with 5 bytes queued -> o_count=0, o_empty=1, o_tx_start=0 immediately, and no launch after release until a new push.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_pkg
// Brief    : Shared UART definitions: transmitter constants and the state
//            encodings of the TX drain FSM.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_pkg;

  // Transmitter character width (one UART frame carries one byte)
  localparam int unsigned c_UART_DATA_BITS = 8;

  // Drain FSM encodings
  localparam int unsigned c_STATE_W = 2;
  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_ST_IDLE      = 2'd0;
  localparam state_t c_ST_LAUNCH    = 2'd1;
  localparam state_t c_ST_WAIT_ACK  = 2'd2;
  localparam state_t c_ST_WAIT_DONE = 2'd3;

  // Width of a counter able to hold 0..depth inclusive
  function automatic int unsigned f_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Host / transmitter handshake bundle for uart_tx_fifo. The master
//            side drives pushes, the sticky-clear and transmitter busy; the
//            slave side (the FIFO block) drives launch, data and status.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) ();

  localparam int unsigned c_CW = f_cnt_width(DEPTH);

  logic                        i_wr_en;
  logic [c_UART_DATA_BITS-1:0] i_wr_data;
  logic                        i_ovf_clr;
  logic                        i_tx_busy;
  logic                        o_tx_start;
  logic [c_UART_DATA_BITS-1:0] o_tx_data;
  logic                        o_full;
  logic                        o_empty;
  logic [c_CW-1:0]             o_count;
  logic                        o_overflow;
  logic                        o_ack_err;

  modport master (
    output i_wr_en, i_wr_data, i_ovf_clr, i_tx_busy,
    input  o_tx_start, o_tx_data, o_full, o_empty, o_count, o_overflow, o_ack_err
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_ovf_clr, i_tx_busy,
    output o_tx_start, o_tx_data, o_full, o_empty, o_count, o_overflow, o_ack_err
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync
// Brief    : Single-clock FIFO with registered count/full/empty. The head
//            entry is visible combinationally on o_rd_data. A push while full
//            is still accepted when a pop happens on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_wr_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] c_CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_do_rd;
  logic             w_do_wr;

  // A pop frees a slot on the same edge, so a full FIFO can still take a push
  assign w_do_rd   = i_rd_en && !r_empty;
  assign w_do_wr   = i_wr_en && (!r_full || w_do_rd);
  assign o_wr_drop = i_wr_en && !w_do_wr;

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;

  // Occupancy after this edge
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_wr && !w_do_rd) begin
      w_count_nxt = r_count + c_CNT_ONE;
    end else if (!w_do_wr && w_do_rd) begin
      w_count_nxt = r_count - c_CNT_ONE;
    end
  end

  // Storage write; contents are left unreset
  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers, count and flags; flags track the updated count on the same edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO in front of a UART transmitter. A drain FSM launches
//            one byte per start pulse, waits for the transmitter to go busy
//            (with a timeout) and then for it to go idle again.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned CW = f_cnt_width(DEPTH);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [TW-1:0] c_TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] c_TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [TW-1:0]               r_timer;
  logic [c_UART_DATA_BITS-1:0] r_tx_data;
  logic                        r_overflow;
  logic                        r_ack_err;
  logic                        w_ack_tmo;
  logic                        w_pop;

  logic [c_UART_DATA_BITS-1:0] w_fifo_rd_data;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [CW-1:0]               w_fifo_count;
  logic                        w_fifo_drop;

  // The only read-pointer advance is the edge that ends LAUNCH
  assign w_pop = (r_state == c_ST_LAUNCH);

  fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (c_UART_DATA_BITS)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (bus.i_wr_en),
    .i_wr_data (bus.i_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rd_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count),
    .o_wr_drop (w_fifo_drop)
  );

  // Drain FSM next-state and ack-timeout detection
  always_comb begin
    w_state_nxt = r_state;
    w_ack_tmo   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (!w_fifo_empty && !bus.i_tx_busy) begin
          w_state_nxt = c_ST_LAUNCH;
        end
      end
      c_ST_LAUNCH: begin
        w_state_nxt = c_ST_WAIT_ACK;
      end
      c_ST_WAIT_ACK: begin
        if (bus.i_tx_busy) begin
          w_state_nxt = c_ST_WAIT_DONE;
        end else if (r_timer == c_TMO_LAST) begin
          w_state_nxt = c_ST_IDLE;
          w_ack_tmo   = 1'b1;
        end
      end
      c_ST_WAIT_DONE: begin
        if (!bus.i_tx_busy) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // State, ack timer and launch data; the head byte is captured on entry to
  // LAUNCH so it is already stable when the transmitter samples the pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= c_ST_IDLE;
      r_timer   <= '0;
      r_tx_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_ST_WAIT_ACK && !bus.i_tx_busy && !w_ack_tmo) begin
        r_timer <= r_timer + c_TMR_ONE;
      end else begin
        r_timer <= '0;
      end
      if (r_state == c_ST_IDLE && w_state_nxt == c_ST_LAUNCH) begin
        r_tx_data <= w_fifo_rd_data;
      end
    end
  end

  // Sticky error flags; a set on the same edge as a clear wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
      r_ack_err  <= 1'b0;
    end else begin
      if (w_fifo_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_ack_tmo) begin
        r_ack_err <= 1'b1;
      end else if (bus.i_ovf_clr) begin
        r_ack_err <= 1'b0;
      end
    end
  end

  assign bus.o_tx_start = (r_state == c_ST_LAUNCH);
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_full     = w_fifo_full;
  assign bus.o_empty    = w_fifo_empty;
  assign bus.o_count    = w_fifo_count;
  assign bus.o_overflow = r_overflow;
  assign bus.o_ack_err  = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo with a simple
//            transmitter model (busy one cycle after start, fixed length).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int unsigned DEPTH       = 16;
  localparam int unsigned ACK_TIMEOUT = 15;
  localparam int          TX_LEN      = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Transmitter model controls
  logic       force_busy = 1'b0;
  logic       no_ack     = 1'b0;
  int         busy_cnt   = 0;
  int         n_viol     = 0;
  logic [7:0] rx[$];

  assign bus.i_tx_busy = force_busy | (busy_cnt != 0);

  // Transmitter model: records every launched byte, goes busy on the next cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 0;
    end else begin
      if (bus.o_tx_start) begin
        rx.push_back(bus.o_tx_data);
        if (bus.i_tx_busy) n_viol <= n_viol + 1;
        if (!no_ack) busy_cnt <= TX_LEN;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_data = d;
    tick();
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("rx_arrival", 32'(rx.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.i_tx_busy && k < 200) begin
      tick();
      k++;
    end
    check("busy_release", 32'(bus.i_tx_busy), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_data = 8'h00;
    bus.i_ovf_clr = 1'b0;
    rst_n         = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_count",    32'(bus.o_count),    32'd0);
    check("rst_empty",    32'(bus.o_empty),    32'd1);
    check("rst_full",     32'(bus.o_full),     32'd0);
    check("rst_start",    32'(bus.o_tx_start), 32'd0);
    check("rst_data",     32'(bus.o_tx_data),  32'h00);
    check("rst_overflow", 32'(bus.o_overflow), 32'd0);
    check("rst_ack_err",  32'(bus.o_ack_err),  32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_start", 32'(bus.o_tx_start), 32'd0);

    // Single byte: start is sampled high on the second edge after the push
    push(8'hA5);
    check("single_count",  32'(bus.o_count),    32'd1);
    check("single_empty",  32'(bus.o_empty),    32'd0);
    check("single_start0", 32'(bus.o_tx_start), 32'd0);
    tick();
    check("single_start1", 32'(bus.o_tx_start), 32'd1);
    check("single_data",   32'(bus.o_tx_data),  32'hA5);
    tick();
    check("single_start2", 32'(bus.o_tx_start), 32'd0);
    check("single_popped", 32'(bus.o_empty),    32'd1);
    check("single_cnt0",   32'(bus.o_count),    32'd0);
    check("single_hold",   32'(bus.o_tx_data),  32'hA5);
    wait_idle();
    check("single_rx_n",   32'(rx.size()),      32'd1);
    check("single_rx_d",   32'(rx[0]),          32'hA5);

    // Burst of 16: one pop lands two edges in, so 15 remain after the last push
    rx.delete();
    for (int i = 1; i <= 16; i++) push(8'(i));
    check("burst_count", 32'(bus.o_count), 32'd15);
    check("burst_full",  32'(bus.o_full),  32'd0);
    wait_rx(16, 16 * (TX_LEN + 6) + 50);
    wait_idle();
    check("burst_rx_n", 32'(rx.size()), 32'd16);
    for (int i = 0; i < 16; i++) check("burst_order", 32'(rx[i]), 32'(i + 1));
    check("burst_no_start_busy", 32'(n_viol), 32'd0);
    check("burst_empty", 32'(bus.o_empty), 32'd1);

    // Overflow with the transmitter stalled
    rx.delete();
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    check("fill_count", 32'(bus.o_count),    32'd16);
    check("fill_full",  32'(bus.o_full),     32'd1);
    check("fill_ovf",   32'(bus.o_overflow), 32'd0);
    push(8'hFF);
    check("ovf_set",    32'(bus.o_overflow), 32'd1);
    check("ovf_count",  32'(bus.o_count),    32'd16);
    check("ovf_full",   32'(bus.o_full),     32'd1);
    bus.i_ovf_clr = 1'b1;
    tick();
    bus.i_ovf_clr = 1'b0;
    check("ovf_clr",    32'(bus.o_overflow), 32'd0);
    bus.i_ovf_clr = 1'b1;
    push(8'hFF);
    bus.i_ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(bus.o_overflow), 32'd1);
    bus.i_ovf_clr = 1'b1;
    tick();
    bus.i_ovf_clr = 1'b0;
    check("ovf_clr2",   32'(bus.o_overflow), 32'd0);
    check("stall_no_tx", 32'(rx.size()),     32'd0);

    // Push during LAUNCH with the FIFO full
    force_busy = 1'b0;
    tick();
    check("sim_start", 32'(bus.o_tx_start), 32'd1);
    check("sim_data",  32'(bus.o_tx_data),  32'h20);
    push(8'h77);
    check("sim_count", 32'(bus.o_count),    32'd16);
    check("sim_full",  32'(bus.o_full),     32'd1);
    check("sim_ovf",   32'(bus.o_overflow), 32'd0);
    wait_rx(17, 17 * (TX_LEN + 6) + 50);
    wait_idle();
    check("sim_rx_n", 32'(rx.size()), 32'd17);
    for (int i = 0; i < 16; i++) check("sim_order", 32'(rx[i]), 32'h20 + 32'(i));
    check("sim_last", 32'(rx[16]), 32'h77);
    check("sim_no_start_busy", 32'(n_viol), 32'd0);

    // Ack timeout: error flag rises 15 cycles after entering WAIT_ACK
    rx.delete();
    no_ack = 1'b1;
    push(8'h3C);
    push(8'h3D);
    check("tmo_start", 32'(bus.o_tx_start), 32'd1);
    check("tmo_data",  32'(bus.o_tx_data),  32'h3C);
    tick();
    repeat (14) tick();
    check("tmo_not_yet", 32'(bus.o_ack_err), 32'd0);
    tick();
    check("tmo_ack_err", 32'(bus.o_ack_err),  32'd1);
    check("tmo_idle",    32'(bus.o_tx_start), 32'd0);
    tick();
    check("tmo_next_start", 32'(bus.o_tx_start), 32'd1);
    check("tmo_next_data",  32'(bus.o_tx_data),  32'h3D);
    repeat (20) tick();
    check("tmo_empty", 32'(bus.o_empty), 32'd1);
    bus.i_ovf_clr = 1'b1;
    tick();
    bus.i_ovf_clr = 1'b0;
    check("tmo_clr", 32'(bus.o_ack_err), 32'd0);
    no_ack = 1'b0;

    // Reset during WAIT_DONE with 5 bytes queued
    rx.delete();
    for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
    check("mid_count", 32'(bus.o_count), 32'd5);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus.o_count),    32'd0);
    check("mid_rst_empty", 32'(bus.o_empty),    32'd1);
    check("mid_rst_full",  32'(bus.o_full),     32'd0);
    check("mid_rst_start", 32'(bus.o_tx_start), 32'd0);
    check("mid_rst_data",  32'(bus.o_tx_data),  32'h00);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.o_tx_start) seen++;
    end
    check("mid_no_launch", 32'(seen), 32'd0);
    push(8'h66);
    check("mid_new_start0", 32'(bus.o_tx_start), 32'd0);
    tick();
    check("mid_new_start1", 32'(bus.o_tx_start), 32'd1);
    check("mid_new_data",   32'(bus.o_tx_data),  32'h66);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
